// File: rtl/axi_lite_rd_arb.sv
// Two-master to one-slave AXI4-Lite read arbiter, one outstanding transaction.
// Define RD_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise master 1 always wins.
module axi_lite_rd_arb (
  input  logic        aclk,
  input  logic        areset,
  // master 0 (instruction cache)
  input  logic        s0_arvalid,
  output logic        s0_arready,
  input  logic [31:0] s0_araddr,
  input  logic [2:0]  s0_arprot,
  output logic        s0_rvalid,
  input  logic        s0_rready,
  output logic [31:0] s0_rdata,
  output logic [1:0]  s0_rresp,
  // master 1 (data cache)
  input  logic        s1_arvalid,
  output logic        s1_arready,
  input  logic [31:0] s1_araddr,
  input  logic [2:0]  s1_arprot,
  output logic        s1_rvalid,
  input  logic        s1_rready,
  output logic [31:0] s1_rdata,
  output logic [1:0]  s1_rresp,
  // memory side
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp
);

`ifdef RD_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state;
  logic        grant;
  logic        last;
  logic        arvalid_q;
  logic [31:0] addr_q;
  logic [2:0]  prot_q;

  logic [1:0]  req;
  logic        win;
  logic        idle_ok;
  logic        in_data;
  logic        ar_hs;
  logic        r_hs;

  assign req = {s1_arvalid, s0_arvalid};

  // Tie-break only matters when both request; a lone requester always wins.
  always_comb begin
    win = req[1];
    if (&req)
      win = RR_EN ? ~last : 1'b1;
  end

  // arready is held low while reset is asserted even though state is already IDLE
  assign idle_ok    = areset && (state == IDLE);
  assign s0_arready = idle_ok && s0_arvalid && !win;
  assign s1_arready = idle_ok && s1_arvalid && win;
  assign ar_hs      = s0_arready || s1_arready;

  assign in_data   = (state == DATA);
  assign m_rready  = in_data && (grant ? s1_rready : s0_rready);
  assign s0_rvalid = in_data && !grant && m_rvalid;
  assign s1_rvalid = in_data && grant && m_rvalid;
  assign r_hs      = m_rvalid && m_rready;

  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;
  assign s0_rresp = m_rresp;
  assign s1_rresp = m_rresp;

  assign m_arvalid = arvalid_q;
  assign m_araddr  = addr_q;
  assign m_arprot  = prot_q;

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      state     <= IDLE;
      grant     <= 1'b0;
      last      <= 1'b1;
      arvalid_q <= 1'b0;
      addr_q    <= '0;
      prot_q    <= '0;
    end else begin
      case (state)
        IDLE: if (ar_hs) begin
          grant     <= win;
          addr_q    <= win ? s1_araddr : s0_araddr;
          prot_q    <= win ? s1_arprot : s0_arprot;
          arvalid_q <= 1'b1;
          state     <= ADDR;
        end
        ADDR: if (m_arready) begin
          arvalid_q <= 1'b0;
          state     <= DATA;
        end
        DATA: if (r_hs) begin
          last  <= grant;
          state <= IDLE;
        end
        default: begin
          arvalid_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/axi_lite_rd_arb.md
# axi_lite_rd_arb

Two-master to one-slave AXI4-Lite read-channel arbiter. It merges the instruction-cache and data-cache read ports into a single read port on `axi_memory`, so the memory model can drop to one read channel. It sits directly downstream of `i_cache`/`d_cache` (AR/R) and upstream of the memory read port, and it carries one outstanding transaction at a time.

## Interface
- No parameters. Address and data widths are fixed at 32; `arprot` is 3 bits and `rresp` is 2 bits.
- `aclk` in 1: single clock, rising edge.
- `areset` in 1: asynchronous, active-low reset.
- `s0_arvalid`/`s0_arready` in/out 1: AR handshake, instruction master (`i_cache`).
- `s0_araddr` in 32, `s0_arprot` in 3: AR payload, master 0.
- `s0_rvalid`/`s0_rready` out/in 1: R handshake, master 0.
- `s0_rdata` out 32, `s0_rresp` out 2: R payload, master 0.
- `s1_*`: identical set for the data master (`d_cache`).
- `m_arvalid`/`m_arready` out/in 1: AR handshake toward memory.
- `m_araddr` out 32, `m_arprot` out 3: forwarded AR payload.
- `m_rvalid`/`m_rready` in/out 1: R handshake from memory.
- `m_rdata` in 32, `m_rresp` in 2: R payload from memory.

## Operation

**FSM states:** IDLE, ADDR, DATA. A `grant` register (0 or 1) and a `last` register (last completed master) support arbitration.

**IDLE**
- Arbitrate among the asserted `s*_arvalid`.
- Assert `sN_arready` combinationally for the winner only.
- On the handshake, latch `araddr`/`arprot` into registers, set `grant`, and go to ADDR.
- If neither master requests, stay in IDLE.

**ADDR**
- `m_arvalid`=1 with the latched payload; both `s*_arready`=0.
- On `m_arready`=1, go to DATA.
- `m_araddr`/`m_arprot` hold stable while `m_arvalid` is high.

**DATA**
- `sG_rvalid` = `m_rvalid` and `m_rready` = `sG_rready`, where G is `grant`.
- The non-granted `s*_rvalid`=0.
- On `m_rvalid & m_rready`: set `last` = `grant` and go to IDLE.

**Data paths**
- `s0_rdata`/`s1_rdata`/`s*_rresp` are driven from `m_rdata`/`m_rresp` unconditionally. Consumers qualify them with `rvalid`.
- `rresp` is passed through untouched. SLVERR/DECERR are not intercepted.

**Arbitration**
- Applies only in IDLE, to masters with `arvalid` high in that cycle. See Configuration for the policy.

**Boundary conditions**
- A request arriving while the FSM is in ADDR/DATA waits. Its `arready` stays 0, and the master must hold its AR per AXI.
- A master that drops `arvalid` before a grant is simply not selected; no state is kept.
- Reset asserted mid-transaction returns the FSM to IDLE asynchronously. All outputs take their reset values immediately, and the in-flight response is discarded.

## Timing
- **Reset values:** FSM=IDLE, `grant`=0, `last`=1. `m_arvalid`=0, `m_rready`=0, `s*_rvalid`=0, `m_araddr`=0, `m_arprot`=0. `s*_arready`=0 while reset is asserted.
- **Cycle T:** IDLE with `sN_arvalid`=1 gives a combinational `sN_arready`=1, and the handshake completes in T.
- **Cycle T+1:** `m_arvalid`=1 (registered).
- **R path:** combinational in both directions in DATA, with zero added latency.
- **Back-to-back requests:** after the R handshake in cycle U, the next AR can be accepted in U+1.
- **Minimum occupancy:** 3 cycles per transaction with zero-wait memory.

## Configuration
- **`RD_ARB_ROUND_ROBIN_EN` defined:** round-robin. When both masters request, grant the master ≠ `last`. When one requests, grant it.
- **`RD_ARB_ROUND_ROBIN_EN` undefined:** fixed priority. Master 1 (data) always wins ties, and `last` is still maintained but unused.
- The FSM and handshakes are identical in both builds.

## Test plan
- **Single fetch:** `s0_araddr`=0x0000_0100 with memory returning 0xDEAD_BEEF/OKAY. Required: `m_araddr`=0x100 at T+1, `s0_rdata`=0xDEADBEEF with `s0_rvalid`, and `s1_rvalid` never high.
- **Simultaneous requests** from `s0` (0x10) and `s1` (0x20) after reset:
  - Round-robin build: `s0` is served first, then `s1`.
  - Fixed build: `s1` first, then `s0`.
  - Both receive the correct data in issue order.
- **Backpressure:** `m_arready` is held low for 5 cycles, then `sG_rready` is held low for 3 cycles with `m_rvalid`=1. Required: `m_araddr` stable throughout, `m_rready` tracks `sG_rready`, and no second AR is accepted.
- **Error passthrough:** memory returns `rresp`=2'b10. Required: the granted master sees `rresp`=2'b10 with `rvalid`, and the FSM returns to IDLE.
- **Reset in DATA:** `areset` is driven low while `m_rvalid` is pending. Required: `s*_rvalid`=0 and `m_rready`=0 immediately. After release, a new `s1` request at 0x40 completes normally.
- **Continuous contention for 8 transactions, round-robin build:** grants alternate 0,1,0,1… with no master starved.
